// File: rtl/mmio_uart_tx_pkg.sv
// Constants shared between the IO slave RTL and the core firmware macros:
// IO page decode bit, register word offsets, UART_CNTL bit layout and
// serializer state encodings.
package mmio_uart_tx_pkg;

  localparam int IO_PAGE_BIT = 22;

  localparam logic [2:0] IO_LEDS      = 3'd0;
  localparam logic [2:0] IO_UART_DATA = 3'd1;
  localparam logic [2:0] IO_UART_CNTL = 3'd2;

  localparam int CNTL_FULL_BIT  = 0;
  localparam int CNTL_OVF_BIT   = 1;
  localparam int CNTL_BUSY_BIT  = 2;
  localparam int CNTL_COUNT_LSB = 4;
  localparam int CNTL_COUNT_W   = 5;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  function automatic logic [31:0] pack_cntl(
    input logic                    full,
    input logic                    ovf,
    input logic                    busy,
    input logic [CNTL_COUNT_W-1:0] count
  );
    logic [31:0] w;
    w = '0;
    w[CNTL_FULL_BIT] = full;
    w[CNTL_OVF_BIT]  = ovf;
    w[CNTL_BUSY_BIT] = busy;
    w[CNTL_COUNT_LSB +: CNTL_COUNT_W] = count;
    return w;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Small synchronous FIFO with fall-through read data. A push into a full
// FIFO is still accepted when a pop happens in the same cycle.
module mmio_uart_tx_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // pointer and occupancy next-state; DEPTH is a power of two so pointers wrap on overflow
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: ;
    endcase
  end

  // pointer/count registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage array; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// IO-page slave: LED register plus a FIFO-fed 8N1 UART transmitter.
//
//   state    | meaning
//   TX_IDLE  | line high; pops the next byte as soon as the FIFO has one
//   TX_START | start bit, line low for one bit period
//   TX_DATA  | eight data bits, LSB first, one bit period each
//   TX_STOP  | stop bit, line high for one bit period
//
// txd is registered, so the line lags the state by one cycle.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD_RATE   = 115200,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_wmask_i,
  input  logic        mem_rstrb_i,
  input  logic        io_sel_i,
  output logic [31:0] mem_rdata_o,
  output logic [4:0]  leds_o,
  output logic        txd_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [2:0]        reg_off;
  logic              wr_en, rd_en;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]        fifo_dout;
  logic [CNT_W-1:0]  fifo_count;
  logic              busy, baud_tc;

  logic [4:0]        leds_q, leds_d;
  logic              ovf_q, ovf_d;
  logic [31:0]       rdata_q, rdata_d;

  tx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              txd_q, txd_d;

  logic              unused_bits;

  assign reg_off   = mem_addr_i[4:2];
  assign wr_en     = io_sel_i && (mem_wmask_i != 4'b0);
  assign rd_en     = io_sel_i && mem_rstrb_i;
  assign fifo_push = wr_en && (reg_off == IO_UART_DATA);
  assign busy      = !fifo_empty || (state_q != TX_IDLE);
  assign baud_tc   = (baud_q == BAUD_LAST);

  // the page bit arrives pre-decoded as io_sel_i; upper address and store bits are not used here
  assign unused_bits = ^{mem_addr_i[31:IO_PAGE_BIT+1], mem_addr_i[IO_PAGE_BIT],
                         mem_addr_i[IO_PAGE_BIT-1:5], mem_addr_i[1:0], mem_wdata_i[31:8]};

  assign mem_rdata_o = rdata_q;
  assign leds_o      = leds_q;
  assign txd_o       = txd_q;

  mmio_uart_tx_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (mem_wdata_i[7:0]),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // register writes, sticky overflow and read-data capture
  always_comb begin
    leds_d  = leds_q;
    ovf_d   = ovf_q;
    rdata_d = rdata_q;
    if (wr_en && (reg_off == IO_LEDS)) leds_d = mem_wdata_i[4:0];
    if (wr_en && (reg_off == IO_UART_CNTL) && mem_wdata_i[CNTL_OVF_BIT]) ovf_d = 1'b0;
    if (fifo_push && fifo_full && !fifo_pop) ovf_d = 1'b1;
    if (rd_en) begin
      case (reg_off)
        IO_LEDS:      rdata_d = {27'b0, leds_q};
        IO_UART_CNTL: rdata_d = pack_cntl(fifo_full, ovf_q, busy, CNTL_COUNT_W'(fifo_count));
        default:      rdata_d = '0;
      endcase
    end
  end

  // serializer next-state, FIFO pop and line level
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    txd_d    = 1'b1;
    case (state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          baud_d   = '0;
          state_d  = TX_START;
        end
      end
      TX_START: begin
        txd_d = 1'b0;
        if (baud_tc) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = TX_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      TX_DATA: begin
        txd_d = shift_q[0];
        if (baud_tc) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) state_d = TX_STOP;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (baud_tc) begin
          baud_d  = '0;
          state_d = TX_IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // all block state; reset abandons any frame and returns the line high
  always_ff @(posedge clk) begin
    if (!resetn) begin
      leds_q  <= '0;
      ovf_q   <= 1'b0;
      rdata_q <= '0;
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      leds_q  <= leds_d;
      ovf_q   <= ovf_d;
      rdata_q <= rdata_d;
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

endmodule
